coin_key_encoder: RTL and testbench
===================================

Name: coin_key_encoder

Overview:
- Upstream front end of the vending-machine FSM.
- Takes three raw, bouncing, active-low push-buttons: insert 0.5 yuan, insert 1 yuan, and cancel/refund.
- Synchronises and debounces each button, detects a press, and emits a one-cycle 3-bit coin code on `coins`.
- The vending FSM consumes `coins` directly: 3'b011 = 0.5 yuan, 3'b101 = 1 yuan, 3'b000 = cancel/refund, any other value = no event.

Parameters:
- CNT_MAX, 999_999: debounce stable-low time in clk cycles (20 ms at 50 MHz). Legal range ≥2. Benches use 4.
- LONG_MAX, 49_999_999: extra hold cycles required for cancel when CANCEL_LONGPRESS_EN is defined (1 s at 50 MHz). Benches use 8.
- IDLE_CODE, 3'b111: value driven on `coins` when there is no event. Must not equal 3'b000, 3'b011 or 3'b101.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_half_n  input  1  raw 0.5-yuan button, active-low, asynchronous to clk
- key_one_n  input  1  raw 1-yuan button, active-low, asynchronous to clk
- key_cancel_n  input  1  raw cancel button, active-low, asynchronous to clk
- coins  output  3  registered coin code to the vending FSM
- key_busy  output  1  registered; high while any synchronised key is low

Behaviour:
- Decided: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All synchroniser flops reset to 1.
  - All debounce counters reset to 0.
  - coins resets to IDLE_CODE; key_busy resets to 0.
- Synchroniser: each key passes through a 2-flop synchroniser. Only the second-stage output (ks) is used downstream.
- Debounce, per key:
  - If ks==1, the counter clears to 0.
  - If ks==0 and counter<CNT_MAX, the counter increments.
  - If ks==0 and counter==CNT_MAX, the counter saturates.
  - press flag (combinational) = ks==0 && counter==CNT_MAX-1. It fires exactly once per continuous stable-low period.
- Bounce: any ks high sample restarts the count. A press shorter than CNT_MAX stable-low cycles produces no event.
- Latency:
  - Key held low from the sampling edge E0 gives `coins` = code for exactly one cycle after edge E0+CNT_MAX+1 (edges counted from E0 = edge 0).
  - coins then returns to IDLE_CODE.
- Holding a key never repeats its event. A new event requires release (ks high ≥1 cycle) and a fresh debounce.
- Encoding:
  - half → 3'b011
  - one → 3'b101
  - cancel → 3'b000
- Simultaneous press flags in the same cycle: priority cancel > one > half. Losing flags are discarded, not queued.
- Flags in different cycles each produce their own one-cycle event. Back-to-back events are legal.
- key_busy = registered OR of the inverted ks values.
- Reset mid-press: all state clears immediately. After release of reset, a still-held key must debounce again from 0 and emits exactly one event.

Optional Feature:
- Macro: CANCEL_LONGPRESS_EN.
- Defined:
  - The cancel counter saturates at CNT_MAX+LONG_MAX.
  - The cancel flag fires at counter==CNT_MAX+LONG_MAX-1.
  - Releasing cancel earlier emits nothing.
  - The half and one keys are unchanged.
- Undefined: cancel debounces exactly like the other keys, with CNT_MAX.

Test Plan (CNT_MAX=4, LONG_MAX=8):
1. Reset, all keys high for 20 cycles → coins==3'b111 throughout, key_busy==0.
2. key_half_n low from edge E0, held for 20 cycles → coins==3'b011 only in the cycle after edge E0+5, and 3'b111 otherwise. key_busy high from 2 cycles after E0 until 2 cycles after release. No repeat event while held.
3. key_one_n bounces (low 2 cycles, high 1, low 3, high 1), then held low → exactly one 3'b101, timed from the start of the final stable-low run. No event from the bounces.
4. key_one_n and key_half_n go low on the same edge → exactly one cycle of 3'b101 and no 3'b011. Then key_half_n low 1 cycle later than key_one_n → 3'b101 followed by 3'b011 on the next cycle.
5. key_cancel_n held low for 20 cycles → 3'b000 for one cycle. With CANCEL_LONGPRESS_EN: a 10-cycle hold gives no event; a 20-cycle hold gives 3'b000 in the cycle after edge E0+13.
6. rst_n asserted while key_half_n is held and the counter is at 2 → coins==3'b111 immediately. After rst_n release with the key still held → exactly one 3'b011, 5 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/coin_key_encoder.sv
// Coin/key front end: 2-flop sync, debounce and press detect
// for three active-low buttons, encoded to a one-cycle coin code.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_half_n   raw 0.5-yuan button (active-low, async)
//   key_one_n    raw 1-yuan button (active-low, async)
//   key_cancel_n raw cancel/refund button (active-low, async)
//   coins        registered code: 011 half, 101 one, 000 cancel,
//                IDLE_CODE otherwise
//   key_busy     registered, high while any synced key is low
//
// Optional: define CANCEL_LONGPRESS_EN to make cancel need an extra
// LONG_MAX cycles of stable-low hold before it fires.

module coin_key_encoder #(
    parameter int unsigned CNT_MAX   = 999_999,
    parameter int unsigned LONG_MAX  = 49_999_999,
    parameter logic [2:0]  IDLE_CODE = 3'b111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_half_n,
    input  logic       key_one_n,
    input  logic       key_cancel_n,
    output logic [2:0] coins,
    output logic       key_busy
);

`ifdef CANCEL_LONGPRESS_EN
    localparam int unsigned CANCEL_MAX = CNT_MAX + LONG_MAX;
`else
    localparam int unsigned CANCEL_MAX = CNT_MAX;
`endif

    // CANCEL_MAX >= CNT_MAX, so it sizes every counter.
    localparam int unsigned CW = $clog2(CANCEL_MAX + 1);

    localparam logic [CW-1:0] KEY_LIM    = CW'(CNT_MAX);
    localparam logic [CW-1:0] CANCEL_LIM = CW'(CANCEL_MAX);
    localparam logic [CW-1:0] ONE        = CW'(1);

    localparam logic [2:0] CODE_HALF   = 3'b011;
    localparam logic [2:0] CODE_ONE    = 3'b101;
    localparam logic [2:0] CODE_CANCEL = 3'b000;

    // Bit order everywhere: [0] half, [1] one, [2] cancel.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    ks;
    logic [CW-1:0] cnt [3];
    logic [CW-1:0] lim [3];
    logic [2:0]    press;
    logic [2:0]    code_nxt;

    assign raw = {key_cancel_n, key_one_n, key_half_n};

    assign lim[0] = KEY_LIM;
    assign lim[1] = KEY_LIM;
    assign lim[2] = CANCEL_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b111;
            ks    <= 3'b111;
        end else begin
            sync1 <= raw;
            ks    <= sync1;
        end
    end

    // Counter saturates at its limit, so the flag one step below
    // the limit is seen exactly once per stable-low period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ks[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < lim[i]) begin
                    cnt[i] <= cnt[i] + ONE;
                end
            end
        end
    end

    always_comb begin
        press = 3'b000;
        for (int i = 0; i < 3; i++) begin
            press[i] = !ks[i] && (cnt[i] == lim[i] - ONE);
        end
    end

    // Overlapping flags resolve cancel > one > half; losers drop.
    always_comb begin
        code_nxt = IDLE_CODE;
        priority case (1'b1)
            press[2]: code_nxt = CODE_CANCEL;
            press[1]: code_nxt = CODE_ONE;
            press[0]: code_nxt = CODE_HALF;
            default:  code_nxt = IDLE_CODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coins    <= IDLE_CODE;
            key_busy <= 1'b0;
        end else begin
            coins    <= code_nxt;
            key_busy <= |(~ks);
        end
    end

endmodule

// File: tb/tb_coin_key_encoder.sv
// Scoreboard bench for coin_key_encoder (CNT_MAX=4, LONG_MAX=8).
// Stimulus pushes expected events; a negedge monitor pops them.

module tb_coin_key_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       kh = 1'b1;
    logic       ko = 1'b1;
    logic       kc = 1'b1;
    logic [2:0] coins;
    logic       key_busy;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int c;

    typedef struct {
        int         at;
        logic [2:0] code;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    coin_key_encoder #(
        .CNT_MAX  (4),
        .LONG_MAX (8),
        .IDLE_CODE(3'b111)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_half_n  (kh),
        .key_one_n   (ko),
        .key_cancel_n(kc),
        .coins       (coins),
        .key_busy    (key_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Any non-idle code is an event and must match the queue head.
    always @(negedge clk) begin
        if (rst_n && coins !== 3'b111) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d got=%b want=none",
                         cyc, coins);
            end else begin
                e = sb.pop_front();
                if (e.at != cyc || e.code !== coins) begin
                    bad++;
                    $display("FAIL event cyc=%0d got=%b want=%b@%0d",
                             cyc, coins, e.code, e.at);
                end
            end
        end
    end

    task automatic expect_at(input int at, input logic [2:0] code);
        exp_t x;
        x.at = at;
        x.code = code;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input logic [2:0] got,
                       input logic [2:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b",
                     name, cyc, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1: reset, idle outputs
        #1 rst_n = 1'b0;
        #1 chk("rst_coins", coins, 3'b111);
        chk("rst_busy", {2'b00, key_busy}, 3'b000);
        cycles(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_coins", coins, 3'b111);
            chk("idle_busy", {2'b00, key_busy}, 3'b000);
        end

        // 2: half held 20 cycles, busy timing, no repeat
        @(negedge clk);
        c = cyc;
        kh = 1'b0;
        expect_at(c + 6, 3'b011);
        cycles(2);
        chk("busy_pre", {2'b00, key_busy}, 3'b000);
        cycles(1);
        chk("busy_on", {2'b00, key_busy}, 3'b001);
        cycles(17);
        kh = 1'b1;
        cycles(2);
        chk("busy_hold", {2'b00, key_busy}, 3'b001);
        cycles(1);
        chk("busy_off", {2'b00, key_busy}, 3'b000);
        cycles(8);

        // 3: bouncing one key, then stable low
        ko = 1'b0;
        cycles(2);
        ko = 1'b1;
        cycles(1);
        ko = 1'b0;
        cycles(3);
        ko = 1'b1;
        cycles(1);
        c = cyc;
        ko = 1'b0;
        expect_at(c + 6, 3'b101);
        cycles(12);
        ko = 1'b1;
        cycles(8);

        // 4a: one and half together, one wins
        c = cyc;
        ko = 1'b0;
        kh = 1'b0;
        expect_at(c + 6, 3'b101);
        cycles(12);
        ko = 1'b1;
        kh = 1'b1;
        cycles(8);

        // 4b: half one cycle later, back-to-back events
        c = cyc;
        ko = 1'b0;
        expect_at(c + 6, 3'b101);
        expect_at(c + 7, 3'b011);
        cycles(1);
        kh = 1'b0;
        cycles(12);
        ko = 1'b1;
        kh = 1'b1;
        cycles(8);

        // 5: cancel
`ifdef CANCEL_LONGPRESS_EN
        kc = 1'b0;
        cycles(10);
        kc = 1'b1;
        cycles(8);
        c = cyc;
        kc = 1'b0;
        expect_at(c + 14, 3'b000);
        cycles(20);
        kc = 1'b1;
        cycles(8);
`else
        c = cyc;
        kc = 1'b0;
        expect_at(c + 6, 3'b000);
        cycles(20);
        kc = 1'b1;
        cycles(8);
`endif

        // 6: reset mid-press, re-debounce from zero
        kh = 1'b0;
        cycles(4);
        rst_n = 1'b0;
        #1 chk("midrst_coins", coins, 3'b111);
        chk("midrst_busy", {2'b00, key_busy}, 3'b000);
        cycles(2);
        c = cyc;
        rst_n = 1'b1;
        expect_at(c + 6, 3'b011);
        cycles(14);
        kh = 1'b1;
        cycles(8);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event got=none want=%b@%0d",
                     e.code, e.at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
